// File: rtl/audio_volume_ramp.sv
// Stereo master volume / soft-mute: scales 24-bit PCM by a Q1.15 gain that ramps one STEP per frame toward target.
// Latency: x_data_valid is a 1-cycle strobe 2 clks after x_data_en; data outputs hold between valids.
// Backpressure: none; strobes are accepted every clk while run = 1 and dropped (pipeline flushed) while run = 0.
//
// Ports:
//   clk, reset_n              : clock, asynchronous active-low reset
//   run                       : audio enable; 0 forces gain to 0, flushes the pipeline, ignores strobes
//   mute                      : forces the ramp target to 0
//   vol_wr, vol_msb, vol_lsb  : CPU volume write, latches {vol_msb, vol_lsb}
//   l/r_data_en, l/r_data_in  : input sample strobes and samples
//   l/r_data_valid, l/r_data_out : output strobes and scaled, saturated samples
//   cur_gain, ramp_busy       : status: gain currently applied, ramp in progress
//
// Build option VOL_ZERO_CROSS_EN: when defined, ramp steps are only taken on frames where the
// left sample changes sign, or after 64 consecutive frames without a sign change.

module audio_volume_ramp #(
    parameter int DATA_W = 24,
    parameter int GAIN_W = 16,
    parameter int STEP   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run,
    input  logic              mute,
    input  logic              vol_wr,
    input  logic [7:0]        vol_lsb,
    input  logic [7:0]        vol_msb,
    input  logic              l_data_en,
    input  logic              r_data_en,
    input  logic [DATA_W-1:0] l_data_in,
    input  logic [DATA_W-1:0] r_data_in,
    output logic              l_data_valid,
    output logic              r_data_valid,
    output logic [DATA_W-1:0] l_data_out,
    output logic [DATA_W-1:0] r_data_out,
    output logic [GAIN_W-1:0] cur_gain,
    output logic              ramp_busy
);

    // Q1.15: the binary point sits below the top gain bit.
    localparam int FRAC   = GAIN_W - 1;
    // sample (DATA_W) times zero-extended unsigned gain (GAIN_W+1) fits exactly in this width
    localparam int PROD_W = DATA_W + GAIN_W + 1;

    localparam logic [GAIN_W-1:0] UNITY   = GAIN_W'(1) << FRAC;
    localparam logic [GAIN_W-1:0] STEP_G  = GAIN_W'(STEP);
    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        UP   = 2'b01,
        DOWN = 2'b10
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [GAIN_W-1:0]   vol_reg;
    logic [GAIN_W-1:0]   target;
    logic [GAIN_W-1:0]   gain_nxt;
    logic                step_pend;
    logic                step_ok;

    logic                       l_vld1;
    logic                       r_vld1;
    logic                       l_vld2;
    logic                       r_vld2;
    logic signed [PROD_W-1:0]   l_prod;
    logic signed [PROD_W-1:0]   r_prod;

    // ------------------------------------------------------------------
    // Volume register and ramp target
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vol_reg <= UNITY;
        end else if (vol_wr) begin
            vol_reg <= GAIN_W'({vol_msb, vol_lsb});
        end
    end

    assign target = mute ? '0 : vol_reg;

    // ------------------------------------------------------------------
    // Step qualification
    // ------------------------------------------------------------------
`ifdef VOL_ZERO_CROSS_EN
    logic       prev_sign;
    logic [5:0] nx_cnt;

    // A step is allowed when the left sample changes sign relative to the previous
    // accepted left sample, or when 63 non-crossing frames have already passed
    // (so the 64th such frame is allowed and the timeout restarts).
    assign step_ok = (l_data_in[DATA_W-1] ^ prev_sign) | (nx_cnt == 6'd63);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_sign <= 1'b0;
            nx_cnt    <= '0;
        end else if (!run) begin
            prev_sign <= 1'b0;
            nx_cnt    <= '0;
        end else if (l_data_en) begin
            prev_sign <= l_data_in[DATA_W-1];
            nx_cnt    <= step_ok ? 6'd0 : nx_cnt + 6'd1;
        end
    end
`else
    assign step_ok = 1'b1;
`endif

    // The step is taken on the cycle after the frame's left strobe, so the sample
    // accepted with that strobe is still scaled by the pre-step gain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_pend <= 1'b0;
        end else begin
            step_pend <= run & l_data_en & step_ok;
        end
    end

    // ------------------------------------------------------------------
    // Ramp FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cur_gain <= '0;
        end else begin
            state    <= state_nxt;
            cur_gain <= gain_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Ramp FSM: next state and gain
    // Direction comes from the live comparison rather than the registered
    // state, so a target change mid-ramp reverses on the very next step.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = IDLE;
        gain_nxt  = cur_gain;
        if (!run) begin
            state_nxt = IDLE;
            gain_nxt  = '0;
        end else begin
            if (target > cur_gain) begin
                state_nxt = UP;
            end else if (target < cur_gain) begin
                state_nxt = DOWN;
            end else begin
                state_nxt = IDLE;
            end

            if (step_pend) begin
                case (state_nxt)
                    UP: begin
                        // landing exactly on target keeps cur_gain + STEP below 2^GAIN_W
                        if ((target - cur_gain) <= STEP_G) begin
                            gain_nxt = target;
                        end else begin
                            gain_nxt = cur_gain + STEP_G;
                        end
                    end
                    DOWN: begin
                        if ((cur_gain - target) <= STEP_G) begin
                            gain_nxt = target;
                        end else begin
                            gain_nxt = cur_gain - STEP_G;
                        end
                    end
                    default: gain_nxt = cur_gain;
                endcase
            end
        end
    end

    // Decoded directly from the state flops (IDLE encodes as all zeros).
    assign ramp_busy = (state != IDLE);

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // Arithmetic shift back to sample scale, then clamp to the signed DATA_W range.
    // The shifted value fits in DATA_W bits exactly when every bit from the
    // DATA_W-1 position upward equals the sign.
    function automatic logic [DATA_W-1:0] scale_sat(input logic signed [PROD_W-1:0] prod);
        logic signed [PROD_W-1:0] shifted;
        logic [PROD_W-DATA_W:0]   upper;
        shifted = prod >>> FRAC;
        upper   = shifted[PROD_W-1:DATA_W-1];
        if ((&upper) || (~|upper)) begin
            scale_sat = shifted[DATA_W-1:0];
        end else if (shifted[PROD_W-1]) begin
            scale_sat = SAT_MIN;
        end else begin
            scale_sat = SAT_MAX;
        end
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            l_vld1     <= 1'b0;
            r_vld1     <= 1'b0;
            l_vld2     <= 1'b0;
            r_vld2     <= 1'b0;
            l_prod     <= '0;
            r_prod     <= '0;
            l_data_out <= '0;
            r_data_out <= '0;
        end else begin
            // run = 0 drops everything in flight; data outputs keep their last value
            l_vld1 <= run & l_data_en;
            r_vld1 <= run & r_data_en;
            l_vld2 <= run & l_vld1;
            r_vld2 <= run & r_vld1;

            // Both channels sample the same cur_gain, so coincident strobes scale identically.
            if (run && l_data_en) begin
                l_prod <= $signed({{(GAIN_W+1){l_data_in[DATA_W-1]}}, l_data_in})
                        * $signed({{(DATA_W+1){1'b0}}, cur_gain});
            end
            if (run && r_data_en) begin
                r_prod <= $signed({{(GAIN_W+1){r_data_in[DATA_W-1]}}, r_data_in})
                        * $signed({{(DATA_W+1){1'b0}}, cur_gain});
            end

            if (run && l_vld1) begin
                l_data_out <= scale_sat(l_prod);
            end
            if (run && r_vld1) begin
                r_data_out <= scale_sat(r_prod);
            end
        end
    end

    // Gate with run so no strobe escapes during the cycle run falls.
    assign l_data_valid = l_vld2 & run;
    assign r_data_valid = r_vld2 & run;

endmodule
